// File: rtl/jt51_host_wr_pkg.sv
// Shared types and timing defaults for the JT51 host write initiator.
package jt51_host_wr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP,
    ST_DATA,
    ST_BLANK,
    ST_WAIT
  } state_e;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  localparam int unsigned REQ_W         = 16;
  localparam int unsigned CNT_W         = 8;
  localparam int unsigned DEF_FIFO_AW   = 2;
  localparam int unsigned DEF_WR_LEN    = 1;
  localparam int unsigned DEF_GAP       = 1;
  localparam int unsigned DEF_SKIP_ADDR = 0;
  localparam int unsigned DEF_TOUT_W    = 10;

endpackage

// File: rtl/jt51_host_wr_sfifo.sv
// Small synchronous FIFO with registered pointers and occupancy count.
module jt51_sfifo #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int unsigned DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/jt51_host_wr.sv
// JT51 host write initiator: queues (addr,data) requests and drives the chip
// CPU port as an address write followed by a data write, then waits on busy.
module jt51_host_wr
  import jt51_host_wr_pkg::*;
#(
  parameter int unsigned FIFO_AW   = DEF_FIFO_AW,
  parameter int unsigned WR_LEN    = DEF_WR_LEN,
  parameter int unsigned GAP       = DEF_GAP,
  parameter int unsigned SKIP_ADDR = DEF_SKIP_ADDR,
  parameter int unsigned TOUT_W    = DEF_TOUT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [7:0] dout,
  output logic       write,
  output logic       a0,
  input  logic       busy,
  output logic       idle,
  output logic       tout
);

  localparam logic [CNT_W-1:0]  LEN_M1 = CNT_W'(WR_LEN - 1);
  localparam logic [CNT_W-1:0]  GAP_M1 = CNT_W'(GAP - 1);
  // Exit on the cycle before the counter would hit all-ones so tout lands
  // exactly 2**TOUT_W-1 cycles after entering WAIT.
  localparam logic [TOUT_W-1:0] TLAST  = {{(TOUT_W-1){1'b1}}, 1'b0};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TOUT_W-1:0] tcnt_q, tcnt_d;
  logic [7:0]        dout_q, dout_d;
  logic              write_q, write_d;
  logic              a0_q, a0_d;
  logic              tout_q, tout_d;
  logic [7:0]        cache_q, cache_d;
  logic              cache_vld_q, cache_vld_d;
  logic [7:0]        data_q, data_d;

  logic              fifo_full, fifo_empty, fifo_pop;
  req_t              head;

  assign req_ready = !fifo_full;

  jt51_sfifo #(
    .DW (REQ_W),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_valid && req_ready),
    .din   ({req_addr, req_data}),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tcnt_d      = tcnt_q;
    dout_d      = dout_q;
    write_d     = write_q;
    a0_d        = a0_q;
    tout_d      = tout_q;
    cache_d     = cache_q;
    cache_vld_d = cache_vld_q;
    data_d      = data_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = head.data;
          cnt_d    = LEN_M1;
          write_d  = 1'b1;
          if (SKIP_ADDR != 0 && cache_vld_q && head.addr == cache_q) begin
            state_d = ST_DATA;
            a0_d    = 1'b1;
            dout_d  = head.data;
          end else begin
            state_d     = ST_ADDR;
            a0_d        = 1'b0;
            dout_d      = head.addr;
            cache_d     = head.addr;
            cache_vld_d = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          write_d = 1'b0;
          cnt_d   = GAP_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          write_d = 1'b1;
          a0_d    = 1'b1;
          dout_d  = data_q;
          cnt_d   = LEN_M1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          state_d = ST_BLANK;
          write_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_BLANK: begin
        state_d = ST_WAIT;
        tcnt_d  = '0;
      end
      ST_WAIT: begin
        if (!busy) begin
          state_d = ST_IDLE;
        end else if (tcnt_q == TLAST) begin
          state_d = ST_IDLE;
          tout_d  = 1'b1;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      dout_q      <= '0;
      write_q     <= 1'b0;
      a0_q        <= 1'b0;
      tout_q      <= 1'b0;
      cache_q     <= '0;
      cache_vld_q <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      dout_q      <= dout_d;
      write_q     <= write_d;
      a0_q        <= a0_d;
      tout_q      <= tout_d;
      cache_q     <= cache_d;
      cache_vld_q <= cache_vld_d;
      data_q      <= data_d;
    end
  end

  assign dout  = dout_q;
  assign write = write_q;
  assign a0    = a0_q;
  assign tout  = tout_q;
  assign idle  = fifo_empty && (state_q == ST_IDLE);

endmodule
